sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between two requesters: the instruction-fetch port (inst_*) and the load/store data port (data_*).
- Sits between the pipeline stages and the single memory interface, using the req/addr_ok/data_ok handshake.
- Allows at most one outstanding transaction and returns each response only to its owner.
- Data requests take priority so that load/store stalls resolve before refetch.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; write strobe width is DATA_W/8

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request (read only)
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  DATA_W  fetch read data
data_req  in  1  load/store request
data_wr  in  1  1 = store, 0 = load
data_wstrb  in  DATA_W/8  byte enables for stores
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  load data returned / store completed this cycle
data_rdata  out  DATA_W  load data
mem_req  out  1  request to memory
mem_wr  out  1  write flag to memory
mem_wstrb  out  DATA_W/8  byte enables to memory
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory response valid
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, WAIT.
  - IDLE: no grant held.
  - REQ: grant locked to one requester; mem_req=1 until mem_addr_ok.
  - WAIT: one transaction outstanding; mem_req=0.
- Arbitration (combinational in IDLE):
  - If data_req=1, grant DATA; else if inst_req=1, grant INST.
  - The grant drives mem_req and the mem_* fields in the same cycle (zero-latency request path).
- Accept in the same cycle:
  - If mem_addr_ok=1 while in IDLE with a grant, pulse the owner's *_addr_ok and go to WAIT.
  - If mem_addr_ok=0, go to REQ and lock the grant in owner_q.
- REQ:
  - mem_* fields come from the owner_q requester only.
  - A request arriving at the other port is ignored (its addr_ok stays 0).
  - On mem_addr_ok: pulse the owner's addr_ok and go to WAIT.
  - Requesters hold req and fields stable until addr_ok; the arbiter does not check this.
- WAIT:
  - On mem_data_ok: pulse the owner's *_data_ok, drive *_rdata = mem_rdata, go to IDLE.
  - The next arbitration happens in the following cycle; there is no data_ok-to-req bypass.
- Non-owner outputs: *_data_ok=0 and *_rdata=0 in all cycles.
- mem_wr and mem_wstrb are forced to 0 for INST grants.
- Mode-dependent defaults:
  - mem_wdata is 0 whenever mem_req=0 or the grant is INST.
  - mem_addr is 0 whenever mem_req=0.
- mem_data_ok outside WAIT: ignored, no output pulse.
- Reset (asynchronous, any state including mid-WAIT):
  - State goes to IDLE, owner_q=DATA, and the response of any in-flight transaction is dropped.
  - All outputs are 0 while resetn=0.
- Latency: minimum 2 cycles per transaction (grant+accept, then response), with back-to-back issue every 2 cycles when memory has zero wait.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_grant register (reset DATA) is kept.
  - When both requests are present in IDLE, grant the port not granted last time.
  - last_grant updates on each mem_addr_ok.
- Undefined: fixed data-over-inst priority, and no last_grant register is generated.

Decomposition:
- Shared package holds:
  - owner encoding OWNER_INST=1'b0, OWNER_DATA=1'b1;
  - FSM state encoding ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_WAIT=2'd2.
- One natural sub-module, sram_arb_pick: combinational two-way priority/round-robin selector taking (inst_req, data_req, last_grant) and returning the grant. It is instantiated once.

Test Plan:
- Fetch-only read: inst_req, addr 0x1c000000, mem_addr_ok same cycle, mem_data_ok one cycle later with rdata 0x02800c0c.
  Required: inst_addr_ok at cycle 0; inst_data_ok and inst_rdata=0x02800c0c at cycle 1; data_* outputs stay 0.
- Simultaneous requests: inst_req and data_req (load, addr 0x100) in the same cycle.
  Required: data granted first; the fetch is granted only after data_data_ok. With SRAM_ARB_ROUND_ROBIN_EN and last_grant=DATA, the fetch is granted first.
- Store with wait state: data_wr=1, wstrb 4'b0011, wdata 0xdeadbeef, mem_addr_ok delayed 3 cycles.
  Required: mem_req held with stable fields; an inst_req raised meanwhile gets no addr_ok; data_data_ok pulses once.
- Response routing: fetch outstanding in WAIT while data_req rises, then mem_data_ok with rdata 0x12345678.
  Required: only inst_data_ok pulses; the data request is granted in the next cycle.
- Reset mid-WAIT: resetn low for 1 cycle while a load is outstanding, then a spurious mem_data_ok.
  Required: no *_data_ok pulse; FSM is in IDLE; all outputs are 0 during reset.
- Spurious mem_data_ok in IDLE.
  Required: ignored, no state change.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the two-port SRAM bus arbiter.
package sram_bus_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way grant selector: data-over-inst priority, or alternating on contention
// when SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_arb_pick
  import sram_bus_arbiter_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant
);

  assign grant_valid = inst_req | data_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = OWNER_DATA;
    if (inst_req && data_req) begin
      grant = (last_grant == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
    end else if (inst_req) begin
      grant = OWNER_INST;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = (inst_req && !data_req) ? OWNER_INST : OWNER_DATA;
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one req/addr_ok/data_ok memory port between fetch and load/store,
// one transaction in flight. SRAM_ARB_ROUND_ROBIN_EN enables alternating grants.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     cur_owner;
  owner_e     pick_grant;
  owner_e     last_grant;
  logic       pick_valid;

  sram_arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant),
    .grant_valid(pick_valid),
    .grant      (pick_grant)
  );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= OWNER_DATA;
    end else if (mem_req && mem_addr_ok) begin
      last_grant <= cur_owner;
    end
  end
`else
  assign last_grant = OWNER_DATA;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_DATA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Grant, handshake routing and memory-side mux; the request path is combinational.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cur_owner    = owner_q;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          cur_owner = pick_grant;
          owner_d   = pick_grant;
          mem_req   = 1'b1;
          state_d   = mem_addr_ok ? ARB_WAIT : ARB_REQ;
        end
      end
      ARB_REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_data_ok) begin
          state_d = ARB_IDLE;
          if (owner_q == OWNER_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Requests seen while reset is held must not reach memory.
    if (!resetn) mem_req = 1'b0;

    if (mem_req) begin
      if (cur_owner == OWNER_DATA) begin
        mem_wr    = data_wr;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_addr  = inst_addr;
      end
      if (mem_addr_ok) begin
        if (cur_owner == OWNER_DATA) data_addr_ok = 1'b1;
        else                         inst_addr_ok = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter; honours SRAM_ARB_ROUND_ROBIN_EN in its model.
module tb_sram_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req, mem_wr;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit            own_data;
    bit            accept;
    logic          wr;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  mem_exp_t      mem_q[$];
  logic [DW-1:0] inst_rsp_q[$];
  logic [DW-1:0] data_rsp_q[$];
  int checks   = 0;
  int failures = 0;

  // Requester intent and transaction-level memory-port model.
  bit            inst_pend, data_pend;
  logic [AW-1:0] i_addr, d_addr;
  logic          d_wr;
  logic [SW-1:0] d_strb;
  logic [DW-1:0] d_wdata;
  bit            busy, accepted, own_data, last_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic issue_inst(input logic [AW-1:0] a);
    inst_pend = 1'b1;
    i_addr    = a;
  endtask

  task automatic issue_data(input logic wr, input logic [SW-1:0] s, input logic [AW-1:0] a,
                            input logic [DW-1:0] w);
    data_pend = 1'b1;
    d_wr      = wr;
    d_strb    = s;
    d_addr    = a;
    d_wdata   = w;
  endtask

  // Drive one cycle of inputs and predict what the port must do with them.
  task automatic cycle(input bit maok, input bit mdok, input logic [DW-1:0] rd);
    bit       req_now;
    bit       own;
    mem_exp_t e;
    inst_req    = inst_pend;
    inst_addr   = i_addr;
    data_req    = data_pend;
    data_wr     = d_wr;
    data_wstrb  = d_strb;
    data_addr   = d_addr;
    data_wdata  = d_wdata;
    mem_addr_ok = maok;
    mem_data_ok = mdok;
    mem_rdata   = rd;
    req_now     = 1'b0;
    own         = 1'b1;
    if (!busy) begin
      if (inst_pend || data_pend) begin
        req_now = 1'b1;
        if (inst_pend && data_pend) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          own = !last_data;
`else
          own = 1'b1;
`endif
        end else begin
          own = data_pend;
        end
        busy     = 1'b1;
        accepted = 1'b0;
        own_data = own;
      end
    end else if (!accepted) begin
      req_now = 1'b1;
      own     = own_data;
    end else if (mdok) begin
      if (own_data) data_rsp_q.push_back(rd);
      else          inst_rsp_q.push_back(rd);
      busy = 1'b0;
    end
    if (req_now) begin
      e.own_data = own;
      e.accept   = maok;
      e.addr     = own ? d_addr : i_addr;
      e.wr       = own ? d_wr : 1'b0;
      e.strb     = own ? d_strb : '0;
      e.wdata    = own ? d_wdata : '0;
      mem_q.push_back(e);
      if (maok) begin
        accepted  = 1'b1;
        last_data = own;
        if (own) data_pend = 1'b0;
        else     inst_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    resetn      = 1'b0;
    inst_req    = 1'b1;
    data_req    = 1'b1;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    inst_pend   = 1'b0;
    data_pend   = 1'b0;
    busy        = 1'b0;
    accepted    = 1'b0;
    last_data   = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: compares memory-side requests and per-port responses as they appear.
  always @(negedge clk) begin
    mem_exp_t e;
    if (!resetn) begin
      check("reset_outputs_zero",
            64'(|{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
                  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}), 64'd0);
    end else begin
      if (mem_q.size() > 0 || mem_req) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", 64'(mem_req), 64'd0);
        end else begin
          e = mem_q.pop_front();
          check("mem_req", 64'(mem_req), 64'd1);
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          check("mem_wr", 64'(mem_wr), 64'(e.wr));
          check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
          check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
          check("inst_addr_ok", 64'(inst_addr_ok), 64'(e.accept && !e.own_data));
          check("data_addr_ok", 64'(data_addr_ok), 64'(e.accept && e.own_data));
        end
      end else begin
        check("idle_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
        check("idle_mem_addr", 64'(mem_addr), 64'd0);
        check("idle_mem_wdata", 64'(mem_wdata), 64'd0);
      end
      if (inst_data_ok) begin
        if (inst_rsp_q.size() == 0) check("unexpected_inst_data_ok", 64'(inst_data_ok), 64'd0);
        else check("inst_rdata", 64'(inst_rdata), 64'(inst_rsp_q.pop_front()));
      end else begin
        check("inst_rdata_quiet", 64'(inst_rdata), 64'd0);
      end
      if (data_data_ok) begin
        if (data_rsp_q.size() == 0) check("unexpected_data_data_ok", 64'(data_data_ok), 64'd0);
        else check("data_rdata", 64'(data_rdata), 64'(data_rsp_q.pop_front()));
      end else begin
        check("data_rdata_quiet", 64'(data_rdata), 64'd0);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = '0;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hffff_ffff;
    inst_pend = 1'b0; data_pend = 1'b0;
    i_addr = '0; d_addr = '0; d_wr = 1'b0; d_strb = '0; d_wdata = '0;
    busy = 1'b0; accepted = 1'b0; own_data = 1'b1; last_data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Simultaneous fetch and load right after reset.
    issue_inst(32'h1c00_0004);
    issue_data(1'b0, 4'b0000, 32'h0000_0100, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h1111_2222);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h3333_4444);

    // Fetch-only read.
    issue_inst(32'h1c00_0000);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0280_0c0c);

    // Store held in REQ for three cycles; a fetch raised meanwhile waits.
    issue_data(1'b1, 4'b0011, 32'h0000_0200, 32'hdead_beef);
    cycle(1'b0, 1'b0, 32'h0);
    issue_inst(32'h1c00_0008);
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h5a5a_5a5a);

    // Fetch response while a load waits behind it.
    issue_inst(32'h1c00_000c);
    cycle(1'b1, 1'b0, 32'h0);
    issue_data(1'b0, 4'b0000, 32'h0000_0300, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h1234_5678);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hcafe_f00d);

    // Reset while a load is outstanding, then a stale response.
    issue_data(1'b0, 4'b0000, 32'h0000_0400, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    reset_cycle();
    cycle(1'b0, 1'b1, 32'hbadb_ad00);
    cycle(1'b0, 1'b0, 32'h0);

    // Spurious response with nothing in flight.
    cycle(1'b0, 1'b1, 32'hffff_ffff);
    issue_inst(32'h1c00_0010);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0bad_f00d);

    // Randomised traffic with random memory wait states.
    for (int i = 0; i < 600; i++) begin
      if (!inst_pend && ($urandom_range(0, 2) == 0)) issue_inst($urandom);
      if (!data_pend && ($urandom_range(0, 2) == 0))
        issue_data(1'($urandom_range(0, 1)), SW'($urandom), $urandom, $urandom);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    inst_pend = 1'b0;
    data_pend = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, $urandom);
    @(negedge clk);
    #1;

    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("inst_rsp_q_drained", 64'(inst_rsp_q.size()), 64'd0);
    check("data_rsp_q_drained", 64'(data_rsp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
